mem_port_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single shared 32-bit data-memory port of the KGP-miniRISC multicycle core.
- Requester 0 is instruction fetch; requester 1 is load/store.
- Grants one requester at a time, drives the 2:1 select for the address and write-data muxing, and holds the transaction until the memory acknowledges or a timeout expires.
- Returns read data and a one-cycle ack to the winner; round-robin fairness on ties.

---
 rtl/mem_port_arbiter_pkg.sv | 13 +
 rtl/mem_port_arbiter_if.sv | 25 ++
 rtl/mem_port_arbiter_mux2.sv | 14 +
 rtl/mem_port_arbiter_rr_arb2.sv | 21 ++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter.
// FSM encoding and default timeout.
package mem_port_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int TIMEOUT_DEF = 16;
  localparam int CNT_W_DEF   = 5;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Shared data-memory port bundle.
// master = arbiter side, slave = memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_addr, mem_wdata, mem_we,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_addr, mem_wdata, mem_we,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/mem_port_arbiter_mux2.sv
// Generic 2:1 bus mux.
// s=0 selects a, s=1 selects b.
module mux2 #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         s,
  output logic [W-1:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin grant, combinational.
// prio picks the winner only when both request.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic prio,
  output logic gnt_valid,
  output logic gnt_idx
);

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_idx   = 1'b0;
    unique case (1'b1)
      (req0 & req1):  gnt_idx = prio;
      (req1 & ~req0): gnt_idx = 1'b1;
      default:        gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch vs load/store arbiter for the shared data-memory port.
// One transaction in flight; ack or timeout returns to IDLE.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we1,
  output logic              ack0,
  output logic              ack1,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              sel,
  output logic              busy,
  mem_port_arbiter_if.master mem
);

  localparam logic [CNT_W-1:0] TLAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CMAX  = '1;

  state_e            state_q, state_d;
  logic              prio_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q, addr_m;
  logic [DATA_W-1:0] wdata_q, wdata_m;
  logic              we_q, we_m;
  logic              gnt_valid, gnt_idx;
  logic              grant, done, tmo;
  logic              r0, r1;

  // The requester just acked may still hold req this cycle.
  assign r0 = req0 & ~ack0;
  assign r1 = req1 & ~ack1;

  rr_arb2 u_arb (
    .req0      (r0),
    .req1      (r1),
    .prio      (prio_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  mux2 #(.W(ADDR_W)) u_amux (
    .a (addr0),
    .b (addr1),
    .s (gnt_idx),
    .y (addr_m)
  );

  mux2 #(.W(DATA_W)) u_dmux (
    .a (wdata0),
    .b (wdata1),
    .s (gnt_idx),
    .y (wdata_m)
  );

  assign we_m = gnt_idx ? we1 : we0;

  assign busy          = (state_q == BUSY);
  assign mem.mem_req   = busy;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_we    = we_q;

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    done    = 1'b0;
    tmo     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          grant   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mem.mem_ack) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (TIMEOUT != 0 && cnt_q == TLAST) begin
          tmo     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
      sel     <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
    end else begin
      state_q <= state_d;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      err     <= 1'b0;
      if (grant) begin
        sel     <= gnt_idx;
        addr_q  <= addr_m;
        wdata_q <= wdata_m;
        we_q    <= we_m;
        cnt_q   <= '0;
      end else if (done || tmo) begin
        ack0   <= ~sel;
        ack1   <= sel;
        err    <= tmo;
        rdata  <= (done && !we_q) ? mem.mem_rdata : '0;
        we_q   <= 1'b0;
        prio_q <= ~sel;
      end else if (busy && cnt_q != CMAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed steps plus random traffic
// checked against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int TMO = 16;

  logic        clk;
  logic        rst_n;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, ack1, err, sel, busy;
  logic [31:0] rdata;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mif ();

  mem_port_arbiter #(
    .DATA_W  (32),
    .ADDR_W  (32),
    .TIMEOUT (TMO),
    .CNT_W   (5)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0   (req0),
    .addr0  (addr0),
    .wdata0 (wdata0),
    .we0    (we0),
    .req1   (req1),
    .addr1  (addr1),
    .wdata1 (wdata1),
    .we1    (we1),
    .ack0   (ack0),
    .ack1   (ack1),
    .err    (err),
    .rdata  (rdata),
    .sel    (sel),
    .busy   (busy),
    .mem    (mif)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          lat   = 1;
  bit          spur  = 0;
  int          bcnt  = 0;
  logic [31:0] mem_s [16];
  logic [31:0] m_mem [16];
  bit          m_prio = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responder: acks in the lat-th BUSY cycle (lat=0: never).
  initial begin
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = '0;
    forever begin
      @(negedge clk);
      mif.mem_ack = 1'b0;
      if (mif.mem_req) begin
        bcnt++;
        if (lat != 0 && bcnt == lat) begin
          mif.mem_ack = 1'b1;
          if (mif.mem_we) mem_s[mif.mem_addr[5:2]] = mif.mem_wdata;
          else mif.mem_rdata = mem_s[mif.mem_addr[5:2]];
        end
      end else begin
        bcnt = 0;
        if (spur) begin
          mif.mem_ack   = 1'b1;
          mif.mem_rdata = 32'hBAD0_BAD0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction from an IDLE start; reqs are driven now and
  // sampled at the next edge.
  task automatic do_xact(input bit q0, input bit q1, input int l);
    int          w, waited, expl;
    logic [31:0] a, d, er;
    logic        wr;
    w  = (q0 && q1) ? int'(m_prio) : (q1 ? 1 : 0);
    a  = (w == 1) ? addr1 : addr0;
    d  = (w == 1) ? wdata1 : wdata0;
    wr = (w == 1) ? we1 : we0;
    lat  = l;
    req0 = q0;
    req1 = q1;
    step();
    chk("grant_req", 32'(mif.mem_req), 32'd1);
    chk("grant_sel", 32'(sel), 32'(w));
    chk("grant_addr", mif.mem_addr, a);
    chk("grant_we", 32'(mif.mem_we), 32'(wr));
    if (wr) chk("grant_wdata", mif.mem_wdata, d);
    expl   = (l == 0) ? TMO : l;
    waited = 0;
    while (!(ack0 || ack1) && waited < 40) begin
      addr0 = $urandom;
      addr1 = $urandom;
      step();
      waited++;
      if (!(ack0 || ack1)) chk("hold_addr", mif.mem_addr, a);
    end
    chk("ack_latency", 32'(waited), 32'(expl));
    chk("ack0", 32'(ack0), 32'(w == 0));
    chk("ack1", 32'(ack1), 32'(w == 1));
    chk("err", 32'(err), 32'(l == 0));
    er = (l == 0 || wr) ? 32'd0 : m_mem[a[5:2]];
    chk("rdata", rdata, er);
    chk("busy_in_ack", 32'(busy), 32'd0);
    if (l != 0 && wr) m_mem[a[5:2]] = d;
    m_prio = (w == 0);
    if (w == 1) req0 = 1'b0;
    else req1 = 1'b0;
    step();
    chk("no_regrant", 32'(mif.mem_req), 32'd0);
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  initial begin
    int          r, l, waited;
    logic [31:0] v;
    rst_n = 1'b0;
    {req0, req1, we0, we1} = '0;
    {addr0, addr1, wdata0, wdata1} = '0;
    for (int i = 0; i < 16; i++) begin
      v        = $urandom | 32'd1;
      mem_s[i] = v;
      m_mem[i] = v;
    end
    mem_s[0] = 32'hDEAD_BEEF;
    m_mem[0] = 32'hDEAD_BEEF;

    #12;
    chk("rst_ctrl", 32'({mif.mem_req, busy, ack0, ack1, err, sel}), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    addr0 = 32'h40;
    we0   = 1'b0;
    do_xact(1'b1, 1'b0, 3);

    // spurious ack in IDLE, then BUSY on req0 with req1 raised late
    addr0 = 32'h44;
    addr1 = 32'h48;
    we0   = 1'b0;
    we1   = 1'b0;
    lat   = 2;
    spur  = 1'b1;
    step();
    spur = 1'b0;
    step();
    chk("spur_ignored", 32'({busy, ack0, ack1, err}), 32'd0);
    req0 = 1'b1;
    step();
    chk("t4_grant_sel", 32'(sel), 32'd0);
    chk("t4_grant_addr", mif.mem_addr, 32'h44);
    addr0 = 32'h88;
    req1  = 1'b1;
    step();
    chk("t4_hold_addr", mif.mem_addr, 32'h44);
    chk("t4_no_ack_yet", 32'({ack0, ack1}), 32'd0);
    step();
    chk("t4_ack0", 32'({ack0, ack1, err}), 32'b100);
    chk("t4_rdata0", rdata, m_mem[1]);
    req0 = 1'b0;
    step();
    chk("t4_grant1_sel", 32'({busy, sel}), 32'b11);
    chk("t4_grant1_addr", mif.mem_addr, 32'h48);
    waited = 0;
    while (!ack1 && waited < 40) begin
      step();
      waited++;
    end
    chk("t4_ack1_latency", 32'(waited), 32'd2);
    chk("t4_rdata1", rdata, m_mem[2]);
    req1   = 1'b0;
    m_prio = 1'b0;
    step();

    for (int i = 0; i < 30; i++) begin
      r      = $urandom_range(1, 3);
      addr0  = {26'($urandom), 6'd0} | 32'({$urandom_range(0, 15), 2'b00});
      addr1  = {26'($urandom), 6'd0} | 32'({$urandom_range(0, 15), 2'b00});
      wdata0 = $urandom;
      wdata1 = $urandom;
      we0    = 1'($urandom);
      we1    = 1'($urandom);
      l      = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
      do_xact(r[0], r[1], l);
    end

    // write timeout on requester 1
    addr1  = 32'h100;
    wdata1 = 32'h1234_5678;
    we1    = 1'b1;
    do_xact(1'b0, 1'b1, 0);
    addr0 = 32'h4C;
    addr1 = 32'h50;
    we0   = 1'b0;
    we1   = 1'b0;
    do_xact(1'b1, 1'b1, 1);

    // async reset mid-BUSY on requester 1
    addr0 = 32'h4C;
    do_xact(1'b1, 1'b0, 2);
    addr1 = 32'h8;
    lat   = 0;
    req1  = 1'b1;
    step();
    chk("pre_rst_busy", 32'({busy, sel}), 32'b11);
    chk("pre_rst_rdata_nz", 32'(rdata != 0), 32'd1);
    step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl",
        32'({mif.mem_req, busy, ack0, ack1, err, sel}), 32'd0);
    chk("async_rst_rdata", rdata, 32'd0);
    req1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // continuous contention after reset: 0,1,0,1
    lat  = 1;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_busy", 32'(busy), 32'd1);
      chk("rr_sel", 32'(sel), 32'(k % 2));
      step();
      chk("rr_ack", 32'({ack0, ack1, busy}),
          (k % 2 == 0) ? 32'b100 : 32'b010);
      if (k == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    step();
    chk("rr_end_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
